// File: rtl/auto_baud_detector.sv
// Auto-baud detector: times the falling edges of a 0x55-style sync character
// on a 2-flop synchronised rx line and reports the rounded bit period in clk cycles.
module auto_baud_detector #(
    parameter int CNT_W      = 16,
    parameter int SYNC_FALLS = 5,
    parameter int DIV_SHIFT  = 3
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             abaud,
    input  logic             rx,
    output logic [CNT_W-1:0] divOut,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam int               FALL_W = $clog2(SYNC_FALLS + 1);
    localparam logic [CNT_W:0]   HALF   = (CNT_W+1)'(1) << (DIV_SHIFT - 1);

    generate
        if (2 * (SYNC_FALLS - 1) != 2 ** DIV_SHIFT) begin : g_bad_params
            $error("auto_baud_detector: 2*(SYNC_FALLS-1) must equal 2**DIV_SHIFT");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, ARM, MEASURE, STOP, DONE, ERR
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FALL_W-1:0]  falls_q, falls_d, falls_inc;
    logic [CNT_W-1:0]   div_q, div_d;
    logic               done_q, err_q, busy_q;
    logic               fall;

    // Rounded divide of the span by the number of bit periods it covers.
    function automatic logic [CNT_W-1:0] round_div(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] s;
        s = {1'b0, c} + HALF;
        return CNT_W'(s >> DIV_SHIFT);
    endfunction

    assign fall      = rx_prev_q & ~rx_sync_q;
    assign falls_inc = falls_q + FALL_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        falls_d = falls_q;
        div_d   = div_q;
        unique case (state_q)
            IDLE: begin
                if (abaud) state_d = ARM;
            end
            ARM: begin
                if (!abaud) begin
                    state_d = IDLE;
                end else if (fall) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    falls_d = FALL_W'(1);
                end
            end
            MEASURE: begin
                // Abort outranks overflow, which outranks counting the final fall.
                if (!abaud) begin
                    state_d = IDLE;
                end else if (cnt_q == '1) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (fall) begin
                        falls_d = falls_inc;
                        if (falls_inc == FALL_W'(SYNC_FALLS)) state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!abaud) begin
                    state_d = IDLE;
                end else if (rx_sync_q) begin
                    state_d = DONE;
                    div_d   = round_div(cnt_q);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            falls_q   <= '0;
            div_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            falls_q   <= falls_d;
            div_q     <= div_d;
            done_q    <= (state_d == DONE);
            err_q     <= (state_d == ERR);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign divOut = div_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_auto_baud_detector.sv
// Bench for auto_baud_detector: three parameterisations share one rx/abaud stream
// and are compared every cycle against a timestamp-based behavioural model.
module tb_auto_baud_detector;

    logic clk = 1'b0;
    logic rstN, abaud, rx;
    always #5 clk = ~clk;

    logic [15:0] div_a;  logic done_a, err_a, busy_a;
    logic [7:0]  div_b;  logic done_b, err_b, busy_b;
    logic [15:0] div_c;  logic done_c, err_c, busy_c;

    auto_baud_detector dut_a (.clk(clk), .rstN(rstN), .abaud(abaud), .rx(rx),
                              .divOut(div_a), .done(done_a), .err(err_a), .busy(busy_a));
    auto_baud_detector #(.CNT_W(8)) dut_b (.clk(clk), .rstN(rstN), .abaud(abaud), .rx(rx),
                              .divOut(div_b), .done(done_b), .err(err_b), .busy(busy_b));
    auto_baud_detector #(.SYNC_FALLS(3), .DIV_SHIFT(2)) dut_c (.clk(clk), .rstN(rstN),
                              .abaud(abaud), .rx(rx), .divOut(div_c), .done(done_c),
                              .err(err_c), .busy(busy_c));

    localparam int CW [3] = '{16, 8, 16};
    localparam int SF [3] = '{5, 5, 3};
    localparam int DS [3] = '{3, 3, 2};

    typedef enum int {M_IDLE, M_ARMED, M_MEAS, M_WAITHI, M_DONE, M_ERR} mmode_t;
    typedef struct {
        mmode_t mode;
        longint t0;
        int     nf;
        longint span;
        longint div;
    } mdl_t;

    mdl_t   m [3];
    bit     rxq [$];
    longint cyc;
    int     n_chk = 0, n_pass = 0;
    int     done_cnt [3] = '{0, 0, 0};
    int     err_cnt  [3] = '{0, 0, 0};

    // Measurement expressed as timestamps: span = edge of last fall - edge of start fall.
    function automatic void mstep(inout mdl_t s, input int cw, input int sf, input int ds,
                                  input bit ab, input bit fl, input bit rs, input longint k);
        longint maxc;
        maxc = (longint'(1) << cw) - 1;
        case (s.mode)
            M_IDLE:  if (ab) s.mode = M_ARMED;
            M_ARMED: begin
                if (!ab) s.mode = M_IDLE;
                else if (fl) begin s.mode = M_MEAS; s.t0 = k; s.nf = 1; end
            end
            M_MEAS: begin
                if (!ab) s.mode = M_IDLE;
                else if (k - s.t0 - 1 == maxc) s.mode = M_ERR;
                else if (fl) begin
                    s.nf++;
                    if (s.nf == sf) begin s.span = k - s.t0; s.mode = M_WAITHI; end
                end
            end
            M_WAITHI: begin
                if (!ab) s.mode = M_IDLE;
                else if (rs) begin
                    s.div  = ((s.span + (longint'(1) << (ds - 1))) >> ds) & maxc;
                    s.mode = M_DONE;
                end
            end
            default: s.mode = M_IDLE;
        endcase
    endfunction

    function automatic void mreset();
        rxq = '{1'b1, 1'b1, 1'b1};
        cyc = 0;
        for (int i = 0; i < 3; i++) m[i] = '{M_IDLE, 0, 0, 0, 0};
    endfunction

    // rxq[0] is the newest pin sample; rxq[1] is the synchronised line, rxq[2] its history.
    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) mreset();
            else begin
                bit fl, rs;
                cyc++;
                rs = rxq[1];
                fl = (rxq[1] == 1'b0) && (rxq[2] == 1'b1);
                for (int i = 0; i < 3; i++) mstep(m[i], CW[i], SF[i], DS[i], abaud, fl, rs, cyc);
                rxq.push_front(rx);
                void'(rxq.pop_back());
            end
        end
    end

    task automatic cmp(input int i, input logic d, input logic e, input logic b, input longint dv);
        logic   ed, ee, eb;
        longint ediv;
        ed = (m[i].mode == M_DONE);
        ee = (m[i].mode == M_ERR);
        eb = (m[i].mode != M_IDLE);
        ediv = m[i].div;
        n_chk++;
        if (d === ed && e === ee && b === eb && dv == ediv) n_pass++;
        else $display("FAIL model_dut%0d t=%0t done/err/busy/div got %b%b%b/%0d expected %b%b%b/%0d",
                      i, $time, d, e, b, dv, ed, ee, eb, ediv);
        if (d === 1'b1) done_cnt[i]++;
        if (e === 1'b1) err_cnt[i]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, done_a, err_a, busy_a, longint'(div_a));
            cmp(1, done_b, err_b, busy_b, longint'(div_b));
            cmp(2, done_c, err_c, busy_c, longint'(div_c));
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Frame: start, 8 data LSB first, stop; bit i spans floor((i+1)*P)-floor(i*P), P=num/den.
    task automatic send_frame(input logic [7:0] b, input int num, input int den, input int lim);
        logic [9:0] bits;
        int c;
        bits = {1'b1, b, 1'b0};
        c = 0;
        for (int i = 0; i < 10; i++) begin
            int len;
            len = ((i + 1) * num) / den - (i * num) / den;
            for (int j = 0; j < len; j++) begin
                if (lim >= 0 && c >= lim) return;
                rx = bits[i];
                tick(1);
                c++;
            end
        end
        rx = 1'b1;
    endtask

    task automatic measure(input int num, input int den, input longint ea, input longint eb,
                           input longint ec);
        int d0;
        d0 = done_cnt[0];
        abaud = 1'b1;
        tick(4);
        send_frame(8'h55, num, den, -1);
        tick(6);
        chk("div_a", longint'(div_a), ea);
        chk("div_b", longint'(div_b), eb);
        chk("div_c", longint'(div_c), ec);
        chk("done_pulses_a", done_cnt[0] - d0, 1);
        abaud = 1'b0;
        tick(3);
    endtask

    initial begin
        int d0, e0, db;
        rstN = 1'b0; abaud = 1'b0; rx = 1'b1;
        tick(3);
        rstN = 1'b1;
        tick(2);
        chk("reset_div_a", longint'(div_a), 0);
        chk("reset_busy_a", longint'(busy_a), 0);
        chk("reset_done_a", longint'(done_a), 0);

        measure(16, 1, 16, 16, 16);
        chk("err_never_a", err_cnt[0], 0);
        measure(13, 1, 13, 13, 13);
        measure(27, 2, 14, 14, 14);

        e0 = err_cnt[1]; db = done_cnt[1];
        measure(40, 1, 40, 14, 40);
        chk("ovf_err_b", err_cnt[1] - e0, 1);
        chk("ovf_nodone_b", done_cnt[1] - db, 0);
        chk("ovf_idle_b", longint'(busy_b), 0);

        d0 = done_cnt[0]; e0 = err_cnt[0];
        abaud = 1'b1;
        tick(4);
        send_frame(8'h55, 16, 1, 70);
        abaud = 1'b0;
        tick(1);
        chk("abort_busy_a", longint'(busy_a), 0);
        rx = 1'b1;
        tick(40);
        chk("abort_nodone_a", done_cnt[0] - d0, 0);
        chk("abort_noerr_a", err_cnt[0] - e0, 0);
        chk("abort_div_a", longint'(div_a), 40);
        measure(16, 1, 16, 16, 16);

        abaud = 1'b1;
        tick(4);
        send_frame(8'h55, 16, 1, 50);
        rstN = 1'b0;
        #1;
        chk("midrst_div_a", longint'(div_a), 0);
        chk("midrst_busy_a", longint'(busy_a), 0);
        chk("midrst_div_c", longint'(div_c), 0);
        abaud = 1'b0; rx = 1'b1;
        tick(2);
        rstN = 1'b1;
        tick(3);
        chk("post_rst_idle_a", longint'(busy_a), 0);

        d0 = done_cnt[0];
        rx = 1'b0;
        tick(3);
        abaud = 1'b1;
        tick(20);
        chk("low_rx_armed_a", longint'(busy_a), 1);
        chk("low_rx_nodone_a", done_cnt[0] - d0, 0);
        rx = 1'b1;
        tick(10);
        send_frame(8'h55, 16, 1, -1);
        tick(6);
        chk("low_rx_div_a", longint'(div_a), 16);
        chk("low_rx_done_a", done_cnt[0] - d0, 1);
        abaud = 1'b0;
        tick(3);

        for (int it = 0; it < 30; it++) begin
            logic [7:0] b;
            int num, den, lim;
            tick($urandom_range(1, 5));
            abaud = 1'b1;
            tick($urandom_range(1, 6));
            b   = ($urandom_range(0, 1) == 0) ? 8'h55 : 8'($urandom);
            num = $urandom_range(8, 34);
            den = $urandom_range(1, 2);
            lim = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 9 * num / den) : -1;
            send_frame(b, num, den, lim);
            if (lim >= 0 && $urandom_range(0, 1) == 0) abaud = 1'b0;
            rx = 1'b1;
            tick($urandom_range(0, 10));
            if ($urandom_range(0, 2) == 0) abaud = 1'b0;
        end
        abaud = 1'b0;
        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
